uart_tx_buffered: RTL and testbench

//  - Buffered UART transmitter: CPU-side byte FIFO feeding a self-contained 8N1 serializer.
//  - Transmit-direction counterpart of the receive path (RX deserializer + 16-entry RX FIFO).
//  - Sits on the UART peripheral's CPU store path; CPU pushes bytes without polling per-byte busy.

---
 rtl/uart_tx_buffered.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Buffered UART transmitter: a DEPTH-entry byte FIFO on the CPU side feeding
//   an 8N1 serializer. With `UART_TX_PARITY_EN defined, an even-parity bit is
//   inserted between the data bits and the stop bit (8E1, 11 bits per frame).
//   With the macro undefined, frames are plain 8N1 (10 bits per frame).
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   write_tx      CPU push strobe, one byte per cycle while high
//   tx_data       byte pushed when write_tx=1
//   clk_per_bit   clock cycles per UART bit, latched at each frame start (0 acts as 1)
//   clr_overflow  clears tx_overflow
//   tx            registered serial line, idle high
//   tx_busy       FIFO non-empty or frame in progress
//   tx_full       FIFO holds DEPTH bytes
//   tx_empty      FIFO holds no bytes
//   tx_count      FIFO occupancy, 0..DEPTH
//   tx_overflow   sticky flag: a push was dropped
//   fsm_state     serializer state, for observation only
//
// Handshake: write_tx is a one-cycle strobe with no ready. A push is taken when
// the FIFO is not full, or when it is full and the serializer pops in the same
// cycle. A push that cannot be taken is dropped and sets tx_overflow.

module uart_tx_buffered #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_tx,
  input  logic [7:0]    tx_data,
  input  logic [15:0]   clk_per_bit,
  input  logic          clr_overflow,
  output logic          tx,
  output logic          tx_busy,
  output logic          tx_full,
  output logic          tx_empty,
  output logic [AW:0]   tx_count,
  output logic          tx_overflow,
  output logic [2:0]    fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop;

  // Serializer
  state_t        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   period_q, period_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d;
  logic          timer_done;
  logic          load;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign tx_full    = (count == FULL_CNT);
  assign tx_empty   = (count == '0);
  assign tx_count   = count;
  assign tx_busy    = (state_q != IDLE) | ~tx_empty;
  assign fsm_state  = state_q;

  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign push_ok    = write_tx & (~tx_full | pop);

  // period_q is never 0, so the subtraction cannot wrap.
  assign timer_done = (timer_q == period_q - 16'd1);

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (write_tx && !push_ok) tx_overflow <= 1'b1;
      else if (clr_overflow)    tx_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------- serializer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      period_q <= 16'd1;
      bit_q    <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    period_d = period_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    load     = 1'b0;
    pop      = 1'b0;
    tx_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (!tx_empty) load = 1'b1;
      end
      START: begin
        if (timer_done) begin
          state_d = DATA;
          timer_d = '0;
          bit_d   = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA: begin
        if (timer_done) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (timer_done) begin
          state_d = STOP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (timer_done) begin
          timer_d = '0;
          // Chain straight into the next start bit so frames are contiguous.
          if (!tx_empty) load = 1'b1;
          else           state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pop      = 1'b1;
      state_d  = START;
      timer_d  = '0;
      bit_d    = '0;
      shift_d  = mem[rd_ptr];
      period_d = (clk_per_bit == 16'd0) ? 16'd1 : clk_per_bit;
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem[rd_ptr];
`endif
    end

    // tx is driven from the next state so the line register changes exactly
    // when the state does.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered. Directed scenarios, one task each, called in
// sequence; a serial receiver with an expected-byte queue checks order across
// FIFO pointer wrap.

module tb_uart_tx_buffered;

`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        write_tx;
  logic [7:0]  tx_data;
  logic [15:0] clk_per_bit;
  logic        clr_overflow;
  logic        tx;
  logic        tx_busy;
  logic        tx_full;
  logic        tx_empty;
  logic [4:0]  tx_count;
  logic        tx_overflow;
  logic [2:0]  fsm_state;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  uart_tx_buffered #(.DEPTH(16), .AW(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .write_tx     (write_tx),
    .tx_data      (tx_data),
    .clk_per_bit  (clk_per_bit),
    .clr_overflow (clr_overflow),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_count     (tx_count),
    .tx_overflow  (tx_overflow),
    .fsm_state    (fsm_state)
  );

  // ------------------------------------------------------ clock and reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset        = 1'b0;
    write_tx     = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  // Expected line level for bit slot k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (F == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // ----------------------------------------------------------- scenarios
  task automatic test_reset();
    reset = 1'b0;
    write_tx = 1'b1;
    tx_data = 8'hAA;
    clk_per_bit = 16'd4;
    clr_overflow = 1'b0;
    repeat (4) tick();
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (tx_count !== 5'd0)  begin errors++; $display("FAIL reset_count: got %0d want 0", tx_count); end
    checks++; if (tx_empty !== 1'b1)  begin errors++; $display("FAIL reset_empty: got %b want 1", tx_empty); end
    checks++; if (tx_full !== 1'b0)   begin errors++; $display("FAIL reset_full: got %b want 0", tx_full); end
    checks++; if (tx_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", tx_overflow); end
    checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    write_tx = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (tx_count !== 5'd0)  begin errors++; $display("FAIL post_reset_count: got %0d want 0", tx_count); end
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL post_reset_tx: got %b want 1", tx); end
  endtask

  task automatic test_single_byte();
    clk_per_bit = 16'd4;
    tx_data = 8'h55;
    write_tx = 1'b1;
    tick();
    write_tx = 1'b0;
    // Byte sits in the FIFO for one cycle before the serializer takes it.
    checks++; if (tx_count !== 5'd1) begin errors++; $display("FAIL single_count_push: got %0d want 1", tx_count); end
    checks++; if (tx_busy !== 1'b1)  begin errors++; $display("FAIL single_busy_push: got %b want 1", tx_busy); end
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL single_tx_push: got %b want 1", tx); end
    tick();
    checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL single_count_pop: got %0d want 0", tx_count); end
    for (int i = 0; i < F*4; i++) begin
      checks++;
      if (tx !== frame_bit(8'h55, i/4)) begin
        errors++; $display("FAIL single_tx cycle %0d: got %b want %b", i, tx, frame_bit(8'h55, i/4));
      end
      checks++;
      if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy cycle %0d: got %b want 1", i, tx_busy); end
      tick();
    end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL single_busy_end: got %b want 0", tx_busy); end
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL single_tx_end: got %b want 1", tx); end
    checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL single_state_end: got %0d want 0", fsm_state); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int exp_cnt;
    clk_per_bit = 16'd2;
    write_tx = 1'b1;
    tx_data = 8'hA5;
    tick();
    tx_data = 8'h3C;
    tick();               // first pop coincides with the second push
    write_tx = 1'b0;
    for (int i = 0; i < 2*F*2; i++) begin
      b = (i < F*2) ? 8'hA5 : 8'h3C;
      exp_cnt = (i < F*2) ? 1 : 0;
      checks++;
      if (tx !== frame_bit(b, (i % (F*2)) / 2)) begin
        errors++; $display("FAIL b2b_tx cycle %0d: got %b want %b", i, tx, frame_bit(b, (i % (F*2)) / 2));
      end
      checks++;
      if (tx_count !== 5'(exp_cnt)) begin
        errors++; $display("FAIL b2b_count cycle %0d: got %0d want %0d", i, tx_count, exp_cnt);
      end
      tick();
    end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", tx_busy); end
  endtask

  task automatic test_full_overflow();
    clk_per_bit = 16'd100;
    write_tx = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tx_data = 8'(i);
      tick();
    end
    write_tx = 1'b0;
    checks++; if (tx_full !== 1'b1)     begin errors++; $display("FAIL ovf_full: got %b want 1", tx_full); end
    checks++; if (tx_count !== 5'd16)   begin errors++; $display("FAIL ovf_count16: got %0d want 16", tx_count); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_none_yet: got %b want 0", tx_overflow); end
    write_tx = 1'b1;
    tx_data = 8'hEE;
    tick();
    write_tx = 1'b0;
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", tx_overflow); end
    checks++; if (tx_count !== 5'd16)   begin errors++; $display("FAIL ovf_count_kept: got %0d want 16", tx_count); end
    // Drop and clear in the same cycle: the drop wins.
    write_tx = 1'b1;
    clr_overflow = 1'b1;
    tick();
    write_tx = 1'b0;
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", tx_overflow); end
    tick();
    clr_overflow = 1'b0;
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", tx_overflow); end
    // First pop was one edge after the first push; the second pop lands F*100
    // edges later. Present a push exactly on that edge.
    repeat (F*100 - 19) tick();
    checks++; if (tx_count !== 5'd16)   begin errors++; $display("FAIL full_before_pop: got %0d want 16", tx_count); end
    write_tx = 1'b1;
    tx_data = 8'hC3;
    tick();
    write_tx = 1'b0;
    checks++; if (tx_count !== 5'd16)   begin errors++; $display("FAIL full_push_pop_count: got %0d want 16", tx_count); end
    checks++; if (tx_full !== 1'b1)     begin errors++; $display("FAIL full_push_pop_full: got %b want 1", tx_full); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL full_push_pop_ovf: got %b want 0", tx_overflow); end
    checks++; if (tx !== 1'b0)          begin errors++; $display("FAIL full_second_start: got %b want 0", tx); end
    apply_reset();
  endtask

  task automatic test_wrap();
    clk_per_bit = 16'd1;
    exp_q.delete();
    fork
      begin : driver
        int t;
        for (int burst = 0; burst < 4; burst++) begin
          write_tx = 1'b1;
          for (int j = 0; j < 10; j++) begin
            tx_data = 8'(burst*10 + j);
            exp_q.push_back(tx_data);
            tick();
          end
          write_tx = 1'b0;
          t = 0;
          while (tx_busy && t < 500) begin tick(); t++; end
          checks++;
          if (t >= 500) begin errors++; $display("FAIL wrap_drain burst %0d: busy=%b want 0", burst, tx_busy); end
        end
      end
      begin : receiver
        logic [7:0] rx;
        logic [7:0] exp;
        int t;
        for (int f = 0; f < 40; f++) begin
          t = 0;
          @(negedge clk);
          while (tx !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
          checks++;
          if (t >= 1000) begin errors++; $display("FAIL wrap_start frame %0d: tx=%b want 0", f, tx); break; end
          for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rx[k] = tx;
          end
          if (F == 11) begin
            @(negedge clk);
            checks++;
            if (tx !== ^rx) begin errors++; $display("FAIL wrap_parity frame %0d: got %b want %b", f, tx, ^rx); end
          end
          @(negedge clk);
          checks++;
          if (tx !== 1'b1) begin errors++; $display("FAIL wrap_stop frame %0d: got %b want 1", f, tx); end
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL wrap_data frame %0d: got %h want none", f, rx);
          end else begin
            exp = exp_q.pop_front();
            if (rx !== exp) begin errors++; $display("FAIL wrap_data frame %0d: got %h want %h", f, rx, exp); end
          end
        end
      end
    join
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    int bad;
    clk_per_bit = 16'd8;
    write_tx = 1'b1;
    tx_data = 8'hFF;
    tick();
    tx_data = 8'h00;
    tick();               // 0xFF popped, 0x00 queued
    write_tx = 1'b0;
    repeat (8 + 3*8 + 3) tick();   // inside data bit 3
    checks++; if (fsm_state !== 3'd2) begin errors++; $display("FAIL mid_state: got %0d want 2", fsm_state); end
    checks++; if (tx_count !== 5'd1)  begin errors++; $display("FAIL mid_count: got %0d want 1", tx_count); end
    reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
    checks++; if (tx_count !== 5'd0)  begin errors++; $display("FAIL mid_rst_count: got %0d want 0", tx_count); end
    checks++; if (tx_busy !== 1'b0)   begin errors++; $display("FAIL mid_rst_busy: got %b want 0", tx_busy); end
    checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL mid_rst_state: got %0d want 0", fsm_state); end
    tick();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_resume: got %0d active cycles want 0", bad); end
    // Reset during a start bit must pull the line high at once.
    write_tx = 1'b1;
    tx_data = 8'h00;
    tick();
    write_tx = 1'b0;
    repeat (3) tick();
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL start_tx_low: got %b want 0", tx); end
    reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL start_rst_tx: got %b want 1", tx); end
    tick();
    reset = 1'b1;
    tick();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [2];
    logic       par [2];
    bytes[0] = 8'h07; par[0] = 1'b1;
    bytes[1] = 8'h03; par[1] = 1'b0;
    clk_per_bit = 16'd4;
    for (int n = 0; n < 2; n++) begin
      write_tx = 1'b1;
      tx_data = bytes[n];
      tick();
      write_tx = 1'b0;
      tick();
      for (int i = 0; i < 44; i++) begin
        checks++;
        if (i/4 == 9) begin
          if (tx !== par[n]) begin errors++; $display("FAIL parity_bit %h cycle %0d: got %b want %b", bytes[n], i, tx, par[n]); end
        end else if (tx !== frame_bit(bytes[n], i/4)) begin
          errors++; $display("FAIL parity_frame %h cycle %0d: got %b want %b", bytes[n], i, tx, frame_bit(bytes[n], i/4));
        end
        tick();
      end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL parity_busy_end %h: got %b want 0", bytes[n], tx_busy); end
    end
  endtask
`endif

  // ---------------------------------------------------------------- main
  initial begin
    reset = 1'b0;
    write_tx = 1'b0;
    tx_data = 8'h00;
    clk_per_bit = 16'd4;
    clr_overflow = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_overflow();
    test_wrap();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
